// File: rtl/rx_fifo.sv
// -----------------------------------------------------------------------------
// rx_fifo
//   Receive-side frame buffer placed directly after the UART receiver.
//   Each rising edge of rxDone captures one frame ({rxError, rxData}) into a
//   depth-entry circular FIFO. The head entry is presented show-ahead on a
//   valid/ready interface. Frames arriving while the FIFO is full (and no pop
//   frees a slot in the same cycle) are dropped and flagged in the sticky
//   overflow bit.
//
// Ports
//   tick         in   clock, all state updates on the rising edge
//   rstN         in   asynchronous active-low reset
//   rxData       in   receiver data, sampled on push
//   rxDone       in   receiver done (level or pulse); rising edge = push
//   rxError      in   receiver framing error, sampled on push
//   rdReady      in   consumer accepts the head entry this cycle
//   clrOverflow  in   clears the sticky overflow flag
//   rdData       out  head entry data (show-ahead)
//   rdError      out  head entry framing-error flag
//   rdValid      out  head entry present (= ~empty)
//   count        out  number of stored entries
//   full         out  count == depth
//   empty        out  count == 0
//   overflow     out  sticky: a frame was dropped while full
// -----------------------------------------------------------------------------
module rx_fifo #(
  parameter int bits  = 8,
  parameter int depth = 16
) (
  input  logic                     tick,
  input  logic                     rstN,
  input  logic [bits-1:0]          rxData,
  input  logic                     rxDone,
  input  logic                     rxError,
  input  logic                     rdReady,
  input  logic                     clrOverflow,
  output logic [bits-1:0]          rdData,
  output logic                     rdError,
  output logic                     rdValid,
  output logic [$clog2(depth):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow
);

  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = '0;
  localparam logic [CW-1:0] CNT_FULL = CW'(depth);

  // Entry layout: {error flag, data}
  logic [bits:0] mem [depth];

  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic          overflow_reg, overflow_next;
  logic          done_q_reg;

  logic push;
  logic pop;
  logic wr_en;
  logic drop;

  // Flags decode from the registered count only, so they never glitch.
  assign empty   = (count_reg == CNT_ZERO);
  assign full    = (count_reg == CNT_FULL);
  assign rdValid = ~empty;
  assign count   = count_reg;
  assign overflow = overflow_reg;

  // done_q_reg resets to 1 so a done already high at reset release is not
  // mistaken for a new frame.
  assign push = rxDone & ~done_q_reg;
  assign pop  = rdValid & rdReady;

  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // still accepted when the consumer is draining.
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    count_next    = count_reg;
    overflow_next = overflow_reg;

    if (wr_en) begin
      wr_ptr_next = wr_ptr_reg + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + PTR_ONE;
    end

    if (wr_en && !pop) begin
      count_next = count_reg + CNT_ONE;
    end else if (!wr_en && pop) begin
      count_next = count_reg - CNT_ONE;
    end

    // A new drop takes priority over a simultaneous clear.
    if (drop) begin
      overflow_next = 1'b1;
    end else if (clrOverflow) begin
      overflow_next = 1'b0;
    end
  end

  always_ff @(posedge tick or negedge rstN) begin
    if (!rstN) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      done_q_reg   <= 1'b1;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
      done_q_reg   <= rxDone;
    end
  end

  // Storage is deliberately not reset; the pointers alone define validity.
  always_ff @(posedge tick) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= {rxError, rxData};
    end
  end

  // Show-ahead read of the head entry.
  assign {rdError, rdData} = mem[rd_ptr_reg];

endmodule

// File: tb/tb_rx_fifo.sv
module tb_rx_fifo;

  localparam int BITS  = 8;
  localparam int DEPTH = 16;

  logic             tick;
  logic             rstN;
  logic [BITS-1:0]  rxData;
  logic             rxDone;
  logic             rxError;
  logic             rdReady;
  logic             clrOverflow;
  logic [BITS-1:0]  rdData;
  logic             rdError;
  logic             rdValid;
  logic [$clog2(DEPTH):0] count;
  logic             full;
  logic             empty;
  logic             overflow;

  rx_fifo #(.bits(BITS), .depth(DEPTH)) dut (
    .tick(tick),
    .rstN(rstN),
    .rxData(rxData),
    .rxDone(rxDone),
    .rxError(rxError),
    .rdReady(rdReady),
    .clrOverflow(clrOverflow),
    .rdData(rdData),
    .rdError(rdError),
    .rdValid(rdValid),
    .count(count),
    .full(full),
    .empty(empty),
    .overflow(overflow)
  );

  initial tick = 1'b0;
  always #5 tick = ~tick;

  int total = 0;
  int bad   = 0;

  // Reference model: a queue of {err, data} frames plus the overflow flag
  // and the previous done level.
  logic [BITS:0] q[$];
  logic          m_ovf;
  logic          m_prev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf  = 1'b0;
    m_prev = 1'b1;
  endtask

  task automatic model_step();
    logic m_push, m_pop, was_full, set_ovf;
    logic [BITS:0] tmp;
    m_push   = rxDone & ~m_prev;
    m_pop    = (q.size() != 0) && rdReady;
    was_full = (q.size() == DEPTH);
    set_ovf  = 1'b0;
    if (m_pop) tmp = q.pop_front();
    if (m_push) begin
      if (!was_full || m_pop) q.push_back({rxError, rxData});
      else set_ovf = 1'b1;
    end
    if (set_ovf) m_ovf = 1'b1;
    else if (clrOverflow) m_ovf = 1'b0;
    m_prev = rxDone;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".count"},    32'(count),    32'(q.size()));
    check({tag, ".empty"},    32'(empty),    32'(q.size() == 0));
    check({tag, ".full"},     32'(full),     32'(q.size() == DEPTH));
    check({tag, ".rdValid"},  32'(rdValid),  32'(q.size() != 0));
    check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    if (q.size() != 0) begin
      check({tag, ".rdData"},  32'(rdData),  32'(q[0][BITS-1:0]));
      check({tag, ".rdError"}, 32'(rdError), 32'(q[0][BITS]));
    end
  endtask

  // Drive inputs, clock once, then check a little after the edge.
  task automatic cycle(input logic d, input logic [BITS-1:0] data, input logic err,
                       input logic rdy, input logic clr, input string tag);
    rxDone      = d;
    rxData      = data;
    rxError     = err;
    rdReady     = rdy;
    clrOverflow = clr;
    @(posedge tick);
    model_step();
    #1;
    check_model(tag);
    $display("txn %s: done=%0b data=%02h err=%0b rdy=%0b clr=%0b -> count=%0d head=%02h ovf=%0b",
             tag, d, data, err, rdy, clr, count, rdData, overflow);
  endtask

  typedef struct {
    logic            done;
    logic [BITS-1:0] data;
    logic            err;
    logic            ready;
    logic            clr;
    int              exp_count;
    logic            exp_valid;
    logic [BITS-1:0] exp_data;
    logic            exp_err;
    logic            exp_ovf;
  } vec_t;

  vec_t vecs[14];

  initial begin
    logic [BITS-1:0] exp_list[$];
    int thr;

    rstN = 1'b0; rxDone = 1'b1; rxData = '0; rxError = 1'b0;
    rdReady = 1'b0; clrOverflow = 1'b0;
    model_reset();

    // rxDone held high across reset release must not push.
    repeat (2) @(posedge tick);
    @(negedge tick);
    rstN = 1'b1;
    #1;
    check("reset.count", 32'(count), 32'd0);
    check("reset.empty", 32'(empty), 32'd1);
    check("reset.full", 32'(full), 32'd0);
    check("reset.rdValid", 32'(rdValid), 32'd0);
    check("reset.overflow", 32'(overflow), 32'd0);
    @(posedge tick); #1;

    //            done data   err rdy clr cnt val data   err ovf
    vecs[0]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1, 1'b1, 8'h3C, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1, 1'b1, 8'h3C, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1, 1'b1, 8'h3C, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1, 1'b1, 8'h3C, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1, 1'b1, 8'h3C, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1, 1'b1, 8'h3C, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 8'h12, 1'b1, 1'b0, 1'b0, 1, 1'b1, 8'h12, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0};

    for (int i = 0; i < 14; i++) begin
      cycle(vecs[i].done, vecs[i].data, vecs[i].err, vecs[i].ready, vecs[i].clr,
            $sformatf("vec%0d", i));
      check($sformatf("vec%0d.tcount", i), 32'(count), 32'(vecs[i].exp_count));
      check($sformatf("vec%0d.tvalid", i), 32'(rdValid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d.tovf", i), 32'(overflow), 32'(vecs[i].exp_ovf));
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d.tdata", i), 32'(rdData), 32'(vecs[i].exp_data));
        check($sformatf("vec%0d.terr", i), 32'(rdError), 32'(vecs[i].exp_err));
      end
    end

    // Fill to full, then drop one frame.
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, "fill");
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "fill");
    end
    check("fill.full", 32'(full), 32'd1);
    check("fill.count", 32'(count), 32'd16);
    cycle(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, "drop");
    check("drop.overflow", 32'(overflow), 32'd1);
    check("drop.count", 32'(count), 32'd16);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "drop");

    // Another drop together with a clear: the set wins.
    cycle(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1, "setwins");
    check("setwins.overflow", 32'(overflow), 32'd1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "clr");
    check("clr.overflow", 32'(overflow), 32'd0);

    // Full, push and pop together: both accepted.
    check("pushpop.head", 32'(rdData), 32'h00);
    cycle(1'b1, 8'h77, 1'b0, 1'b1, 1'b0, "pushpop");
    check("pushpop.count", 32'(count), 32'd16);
    check("pushpop.overflow", 32'(overflow), 32'd0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "pushpop");

    for (int i = 1; i < DEPTH; i++) exp_list.push_back(8'(i));
    exp_list.push_back(8'h77);
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("drain%0d.data", i), 32'(rdData), 32'(exp_list[i]));
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "drain");
    end
    check("drain.empty", 32'(empty), 32'd1);

    // Async reset mid-operation with five entries stored.
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0, 1'b0, "pre_rst");
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "pre_rst");
    end
    check("pre_rst.count", 32'(count), 32'd5);
    rstN = 1'b0;
    #2;
    check("async_rst.count", 32'(count), 32'd0);
    check("async_rst.empty", 32'(empty), 32'd1);
    model_reset();
    #2;
    rstN = 1'b1;
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "post_rst");
    cycle(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, "post_rst");
    check("post_rst.data", 32'(rdData), 32'h5A);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "post_rst");

    // Randomized traffic against the model, alternating drain-heavy and
    // fill-heavy phases so both full and empty boundaries are exercised.
    for (int i = 0; i < 3000; i++) begin
      thr = ((i / 200) % 2 == 0) ? 25 : 85;
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 99) < thr), 1'($urandom_range(0, 19) == 0), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
